// File: rtl/main_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// main_mem_responder_pkg
// Shared definitions for the main-memory responder, its cache controller and
// their benches: default bus/array geometry, the responder FSM state encoding
// and a small request-decode helper.
// -----------------------------------------------------------------------------
package main_mem_responder_pkg;

    localparam int MEM_ADDR_W_DEF  = 32;  // byte-address width
    localparam int MEM_DATA_W_DEF  = 32;  // word width
    localparam int MEM_DEPTH_W_DEF = 10;  // log2 of word count
    localparam int MEM_CNT_W       = 4;   // latency counter width (LATENCY <= 15)

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESP    = 2'd2,
        ST_RELEASE = 2'd3
    } mem_state_e;

    // A request is present whenever either request level is high.
    function automatic logic mem_req_active(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage : main_mem_responder_pkg

// File: rtl/main_mem_responder_sp_ram.sv
// -----------------------------------------------------------------------------
// sp_ram
// Single-port word array: synchronous write, combinational read on the same
// address. Contents are deliberately not reset so that data survives a reset
// of the surrounding responder.
// Ports:
//   iCLK   clock, write occurs on the rising edge when we is high
//   we     write enable
//   addr   word index (shared by read and write)
//   wdata  write data
//   rdata  read data at addr
// -----------------------------------------------------------------------------
module sp_ram #(
    parameter int DATA_W  = 32,
    parameter int DEPTH_W = 10
) (
    input  logic              iCLK,
    input  logic              we,
    input  logic [DEPTH_W-1:0] addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata
);

    logic [DATA_W-1:0] mem_r [0:(1 << DEPTH_W) - 1];

    // Synchronous write port.
    always_ff @(posedge iCLK) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule : sp_ram

// File: rtl/main_mem_responder.sv
// -----------------------------------------------------------------------------
// main_mem_responder
// Fixed-latency main-memory model answering a cache controller. A request is
// captured in IDLE, a down-counter spaces the response LATENCY edges after
// acceptance, a one-cycle ready pulse marks completion, and RELEASE waits for
// the request levels to drop so a held request is serviced only once.
// Ports:
//   iCLK                clock (rising edge)
//   iRST_n              synchronous active-low reset (array is not cleared)
//   cache2mem_addr      byte address, word index = addr[DEPTH_W+1:2]
//   cache2mem_data_out  write data
//   cache2mem_MemRead   read request level
//   cache2mem_MemWrite  write request level (wins if both are high)
//   mem2cache_data_in   read data, held until the next read completes
//   mem2cache_ready     one-cycle completion pulse
//   oBUSY               high whenever the FSM is not in IDLE
//   oERR                sticky error: read+write together or out-of-range addr
// -----------------------------------------------------------------------------
module main_mem_responder
    import main_mem_responder_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W_DEF,
    parameter int DATA_W  = MEM_DATA_W_DEF,
    parameter int DEPTH_W = MEM_DEPTH_W_DEF,
    parameter int LATENCY = 4
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic [ADDR_W-1:0] cache2mem_addr,
    input  logic [DATA_W-1:0] cache2mem_data_out,
    input  logic              cache2mem_MemRead,
    input  logic              cache2mem_MemWrite,
    output logic [DATA_W-1:0] mem2cache_data_in,
    output logic              mem2cache_ready,
    output logic              oBUSY,
    output logic              oERR
);

    localparam logic [MEM_CNT_W-1:0] CNT_LOAD = MEM_CNT_W'(LATENCY - 1);

    mem_state_e               state_r;
    mem_state_e               next_state_s;
    logic [MEM_CNT_W-1:0]     cnt_r;
    logic [DEPTH_W-1:0]       idx_r;
    logic [DATA_W-1:0]        wdata_r;
    logic                     is_wr_r;
    logic                     oor_r;
    logic [DATA_W-1:0]        rdata_r;
    logic                     ready_r;
    logic                     busy_r;
    logic                     err_r;

    logic                     req_s;
    logic                     both_s;
    logic                     addr_oor_s;
    logic                     accept_s;
    logic                     done_s;
    logic                     ram_we_s;
    logic [DATA_W-1:0]        ram_rdata_s;

    // Request decode and transaction milestones.
    always_comb begin
        req_s      = mem_req_active(cache2mem_MemRead, cache2mem_MemWrite);
        both_s     = cache2mem_MemRead & cache2mem_MemWrite;
        // Any bit above the word-index field set means outside the array.
        addr_oor_s = |(cache2mem_addr >> (DEPTH_W + 2));
        accept_s   = (state_r == ST_IDLE) && req_s;
        done_s     = (state_r == ST_WAIT) && (cnt_r == {MEM_CNT_W{1'b0}});
        // Gating with iRST_n makes a reset edge abort the pending write.
        ram_we_s   = done_s && is_wr_r && !oor_r && iRST_n;
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == {MEM_CNT_W{1'b0}}) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                next_state_s = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!cache2mem_MemRead && !cache2mem_MemWrite) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RELEASE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, counter, capture and registered outputs.
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {MEM_CNT_W{1'b0}};
            idx_r   <= {DEPTH_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            is_wr_r <= 1'b0;
            oor_r   <= 1'b0;
            rdata_r <= {DATA_W{1'b0}};
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            // Outputs are registered from the next state so they line up
            // with the state they describe.
            ready_r <= (next_state_s == ST_RESP);
            busy_r  <= (next_state_s != ST_IDLE);

            if (accept_s) begin
                idx_r   <= cache2mem_addr[DEPTH_W+1:2];
                wdata_r <= cache2mem_data_out;
                is_wr_r <= cache2mem_MemWrite;
                oor_r   <= addr_oor_s;
                cnt_r   <= CNT_LOAD;
                err_r   <= err_r | both_s | addr_oor_s;
            end else if ((state_r == ST_WAIT) && (cnt_r != {MEM_CNT_W{1'b0}})) begin
                cnt_r   <= cnt_r - MEM_CNT_W'(1);
            end

            // Read data lands on the edge that enters RESP; writes leave it.
            if (done_s && !is_wr_r) begin
                rdata_r <= oor_r ? {DATA_W{1'b0}} : ram_rdata_s;
            end
        end
    end

    sp_ram #(
        .DATA_W  (DATA_W),
        .DEPTH_W (DEPTH_W)
    ) u_sp_ram (
        .iCLK  (iCLK),
        .we    (ram_we_s),
        .addr  (idx_r),
        .wdata (wdata_r),
        .rdata (ram_rdata_s)
    );

    assign mem2cache_data_in = rdata_r;
    assign mem2cache_ready   = ready_r;
    assign oBUSY             = busy_r;
    assign oERR              = err_r;

endmodule : main_mem_responder

// File: tb/tb_main_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_main_mem_responder
// Directed bench for main_mem_responder with LATENCY=4, DEPTH_W=10.
// -----------------------------------------------------------------------------
module tb_main_mem_responder;

    logic        iCLK;
    logic        iRST_n;
    logic [31:0] cache2mem_addr;
    logic [31:0] cache2mem_data_out;
    logic        cache2mem_MemRead;
    logic        cache2mem_MemWrite;
    logic [31:0] mem2cache_data_in;
    logic        mem2cache_ready;
    logic        oBUSY;
    logic        oERR;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    main_mem_responder #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .DEPTH_W (10),
        .LATENCY (4)
    ) dut (
        .iCLK               (iCLK),
        .iRST_n             (iRST_n),
        .cache2mem_addr     (cache2mem_addr),
        .cache2mem_data_out (cache2mem_data_out),
        .cache2mem_MemRead  (cache2mem_MemRead),
        .cache2mem_MemWrite (cache2mem_MemWrite),
        .mem2cache_data_in  (mem2cache_data_in),
        .mem2cache_ready    (mem2cache_ready),
        .oBUSY              (oBUSY),
        .oERR               (oERR)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // One transaction: request accepted on the next edge, then dropped.
    // lat = edges from acceptance to the ready pulse (-1 if it never came).
    task automatic run_txn(input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output logic [31:0] rdata,
                           output logic busy_acc, output logic rdy_after,
                           output logic busy_after);
        cache2mem_addr     = addr;
        cache2mem_data_out = wdata;
        cache2mem_MemRead  = rd;
        cache2mem_MemWrite = wr;
        tick();
        busy_acc           = oBUSY;
        cache2mem_MemRead  = 1'b0;
        cache2mem_MemWrite = 1'b0;
        cache2mem_addr     = 32'hFFFF_FFFC;
        cache2mem_data_out = 32'h1111_1111;
        lat   = -1;
        rdata = 32'hXXXX_XXXX;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (mem2cache_ready === 1'b1) begin
                lat   = i;
                rdata = mem2cache_data_in;
                break;
            end
        end
        tick();
        rdy_after = mem2cache_ready;
        tick();
        busy_after = oBUSY;
    endtask

    task automatic test_reset();
        iRST_n             = 1'b0;
        cache2mem_addr     = 32'h0;
        cache2mem_data_out = 32'h0;
        cache2mem_MemRead  = 1'b0;
        cache2mem_MemWrite = 1'b0;
        tick();
        tick();
        chk_cnt++;
        if (mem2cache_ready !== 1'b0) $display("FAIL reset_ready got=%b want=0", mem2cache_ready);
        else pass_cnt++;
        chk_cnt++;
        if (oBUSY !== 1'b0) $display("FAIL reset_busy got=%b want=0", oBUSY);
        else pass_cnt++;
        chk_cnt++;
        if (oERR !== 1'b0) $display("FAIL reset_err got=%b want=0", oERR);
        else pass_cnt++;
        chk_cnt++;
        if (mem2cache_data_in !== 32'h0) $display("FAIL reset_data got=%h want=0", mem2cache_data_in);
        else pass_cnt++;
        iRST_n = 1'b1;
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic ba, ra, bf;
        run_txn(1'b0, 1'b1, 32'h4, 32'h0000_0005, lat, rd, ba, ra, bf);
        chk_cnt++;
        if (lat !== 4) $display("FAIL wr_latency got=%0d want=4", lat);
        else pass_cnt++;
        chk_cnt++;
        if (ba !== 1'b1) $display("FAIL wr_busy_at_accept got=%b want=1", ba);
        else pass_cnt++;
        chk_cnt++;
        if (ra !== 1'b0) $display("FAIL wr_ready_one_cycle got=%b want=0", ra);
        else pass_cnt++;
        chk_cnt++;
        if (bf !== 1'b0) $display("FAIL wr_busy_after got=%b want=0", bf);
        else pass_cnt++;
        chk_cnt++;
        if (mem2cache_data_in !== 32'h0) $display("FAIL wr_leaves_data got=%h want=0", mem2cache_data_in);
        else pass_cnt++;
        run_txn(1'b1, 1'b0, 32'h4, 32'h0, lat, rd, ba, ra, bf);
        chk_cnt++;
        if (lat !== 4) $display("FAIL rd_latency got=%0d want=4", lat);
        else pass_cnt++;
        chk_cnt++;
        if (rd !== 32'h0000_0005) $display("FAIL rd_data got=%h want=00000005", rd);
        else pass_cnt++;
        chk_cnt++;
        if (ra !== 1'b0) $display("FAIL rd_ready_one_cycle got=%b want=0", ra);
        else pass_cnt++;
    endtask

    task automatic test_held_request();
        int lat; logic [31:0] rd; logic ba, ra, bf;
        int pulses;
        logic [31:0] seen;
        run_txn(1'b0, 1'b1, 32'h8, 32'h1234_5678, lat, rd, ba, ra, bf);
        cache2mem_addr    = 32'h8;
        cache2mem_MemRead = 1'b1;
        pulses = 0;
        seen   = 32'h0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (mem2cache_ready === 1'b1) begin
                pulses++;
                seen = mem2cache_data_in;
            end
        end
        chk_cnt++;
        if (pulses !== 1) $display("FAIL held_single_pulse got=%0d want=1", pulses);
        else pass_cnt++;
        chk_cnt++;
        if (seen !== 32'h1234_5678) $display("FAIL held_data got=%h want=12345678", seen);
        else pass_cnt++;
        chk_cnt++;
        if (oBUSY !== 1'b1) $display("FAIL held_in_release got=%b want=1", oBUSY);
        else pass_cnt++;
        cache2mem_MemRead = 1'b0;
        tick();
        chk_cnt++;
        if (oBUSY !== 1'b0) $display("FAIL held_release_exit got=%b want=0", oBUSY);
        else pass_cnt++;
        cache2mem_MemRead = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mem2cache_ready === 1'b1) pulses++;
        end
        chk_cnt++;
        if (pulses !== 1) $display("FAIL held_reassert_pulse got=%0d want=1", pulses);
        else pass_cnt++;
        cache2mem_MemRead = 1'b0;
        tick();
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd; logic ba, ra, bf;
        chk_cnt++;
        if (oERR !== 1'b0) $display("FAIL oor_err_before got=%b want=0", oERR);
        else pass_cnt++;
        run_txn(1'b1, 1'b0, 32'h0000_1000, 32'h0, lat, rd, ba, ra, bf);
        chk_cnt++;
        if (lat !== 4) $display("FAIL oor_latency got=%0d want=4", lat);
        else pass_cnt++;
        chk_cnt++;
        if (rd !== 32'h0) $display("FAIL oor_data got=%h want=0", rd);
        else pass_cnt++;
        chk_cnt++;
        if (ra !== 1'b0) $display("FAIL oor_ready_one_cycle got=%b want=0", ra);
        else pass_cnt++;
        chk_cnt++;
        if (oERR !== 1'b1) $display("FAIL oor_err got=%b want=1", oERR);
        else pass_cnt++;
        tick(); tick(); tick();
        chk_cnt++;
        if (oERR !== 1'b1) $display("FAIL oor_err_sticky got=%b want=1", oERR);
        else pass_cnt++;
    endtask

    task automatic test_both_requests();
        int lat; logic [31:0] rd; logic ba, ra, bf;
        iRST_n = 1'b0;
        tick();
        iRST_n = 1'b1;
        chk_cnt++;
        if (oERR !== 1'b0) $display("FAIL both_err_cleared got=%b want=0", oERR);
        else pass_cnt++;
        run_txn(1'b1, 1'b1, 32'hC, 32'hA5A5_A5A5, lat, rd, ba, ra, bf);
        chk_cnt++;
        if (lat !== 4) $display("FAIL both_latency got=%0d want=4", lat);
        else pass_cnt++;
        chk_cnt++;
        if (oERR !== 1'b1) $display("FAIL both_err got=%b want=1", oERR);
        else pass_cnt++;
        run_txn(1'b1, 1'b0, 32'hC, 32'h0, lat, rd, ba, ra, bf);
        chk_cnt++;
        if (rd !== 32'hA5A5_A5A5) $display("FAIL both_readback got=%h want=a5a5a5a5", rd);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] rd; logic ba, ra, bf;
        run_txn(1'b0, 1'b1, 32'h10, 32'h0BAD_F00D, lat, rd, ba, ra, bf);
        cache2mem_addr     = 32'h10;
        cache2mem_data_out = 32'hDEAD_BEEF;
        cache2mem_MemWrite = 1'b1;
        tick();                          // acceptance edge
        cache2mem_MemWrite = 1'b0;
        tick();                          // +1
        tick();                          // +2
        iRST_n = 1'b0;
        tick();                          // reset edge
        iRST_n = 1'b1;
        chk_cnt++;
        if (mem2cache_ready !== 1'b0) $display("FAIL abort_ready got=%b want=0", mem2cache_ready);
        else pass_cnt++;
        chk_cnt++;
        if (oBUSY !== 1'b0) $display("FAIL abort_busy got=%b want=0", oBUSY);
        else pass_cnt++;
        chk_cnt++;
        if (oERR !== 1'b0) $display("FAIL abort_err got=%b want=0", oERR);
        else pass_cnt++;
        run_txn(1'b1, 1'b0, 32'h10, 32'h0, lat, rd, ba, ra, bf);
        chk_cnt++;
        if (ba !== 1'b1) $display("FAIL abort_first_accept got=%b want=1", ba);
        else pass_cnt++;
        chk_cnt++;
        if (lat !== 4) $display("FAIL abort_latency got=%0d want=4", lat);
        else pass_cnt++;
        chk_cnt++;
        if (rd !== 32'h0BAD_F00D) $display("FAIL abort_prior_contents got=%h want=0badf00d", rd);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic ba, ra, bf;
        run_txn(1'b1, 1'b0, 32'h4, 32'h0, lat, rd, ba, ra, bf);
        chk_cnt++;
        if (rd !== 32'h0000_0005) $display("FAIL b2b_first_data got=%h want=00000005", rd);
        else pass_cnt++;
        // run_txn returns right after the edge on which RELEASE exited.
        run_txn(1'b1, 1'b0, 32'h8, 32'h0, lat, rd, ba, ra, bf);
        chk_cnt++;
        if (ba !== 1'b1) $display("FAIL b2b_second_accept got=%b want=1", ba);
        else pass_cnt++;
        chk_cnt++;
        if (lat !== 4) $display("FAIL b2b_second_latency got=%0d want=4", lat);
        else pass_cnt++;
        chk_cnt++;
        if (rd !== 32'h1234_5678) $display("FAIL b2b_second_data got=%h want=12345678", rd);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_held_request();
        test_out_of_range();
        test_both_requests();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_main_mem_responder
